// File: rtl/lcd_timing_gen.sv
// RGB888 parallel-LCD timing generator with pixel-request port and built-in test patterns.
// Counters to pins take 2 cycles for sync, de and colour alike; free-running, no backpressure on pix_req.
module lcd_timing_gen #(
   parameter int          H_SYNC   = 41,
   parameter int          H_BP     = 2,
   parameter int          H_ACTIVE = 480,
   parameter int          H_FP     = 2,
   parameter int          V_SYNC   = 10,
   parameter int          V_BP     = 2,
   parameter int          V_ACTIVE = 272,
   parameter int          V_FP     = 2,
   parameter int          H_W      = 11,
   parameter int          V_W      = 10,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter logic [23:0] SOLID    = 24'h0000FF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     mode,
   output logic           pix_req,
   output logic [H_W-1:0] pix_x,
   output logic [V_W-1:0] pix_y,
   input  logic [23:0]    pix_data,
   output logic           lcd_dclk,
   output logic [7:0]     lcd_r,
   output logic [7:0]     lcd_g,
   output logic [7:0]     lcd_b,
   output logic           lcd_hsync,
   output logic           lcd_vsync,
   output logic           lcd_de,
   output logic           frame_start
);

   localparam logic [31:0] H_LAST = 32'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [31:0] V_LAST = 32'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
   localparam logic [31:0] H_A0   = 32'(H_SYNC + H_BP);
   localparam logic [31:0] H_A1   = 32'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [31:0] V_A0   = 32'(V_SYNC + V_BP);
   localparam logic [31:0] V_A1   = 32'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [31:0] H_SE   = 32'(H_SYNC);
   localparam logic [31:0] V_SE   = 32'(V_SYNC);
   localparam logic [31:0] X_MAX  = 32'(H_ACTIVE - 1);
   localparam logic [31:0] Y_MAX  = 32'(V_ACTIVE - 1);
   localparam logic [31:0] BAR_W  = 32'(H_ACTIVE >> 3);

   localparam logic [1:0] MODE_EXT  = 2'd0;
   localparam logic [1:0] MODE_BARS = 2'd1;
   localparam logic [1:0] MODE_GRID = 2'd2;

   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;
   logic           h_last, v_last, hs, vs, act, first;
   logic           hs_q, vs_q, first_q;
   logic [1:0]     mode_q;
   logic [2:0]     bar;
   logic           on_grid;
   logic [23:0]    colour;

   assign lcd_dclk = ~clk;

   always_comb begin
      h_last = (32'(h_cnt) == H_LAST);
      v_last = (32'(v_cnt) == V_LAST);
      hs     = (32'(h_cnt) < H_SE);
      vs     = (32'(v_cnt) < V_SE);
      act    = (32'(h_cnt) >= H_A0) && (32'(h_cnt) < H_A1) &&
               (32'(v_cnt) >= V_A0) && (32'(v_cnt) < V_A1);
      first  = (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      end else begin
         h_cnt <= h_cnt + H_W'(1);
      end
   end

   // Mode only changes at the frame origin so a frame never mixes patterns.
   always_ff @(posedge clk) begin
      if (rst)        mode_q <= 2'd0;
      else if (first) mode_q <= mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         first_q <= 1'b0;
      end else begin
         pix_req <= act;
         pix_x   <= act ? h_cnt - H_W'(H_A0) : '0;
         pix_y   <= act ? v_cnt - V_W'(V_A0) : '0;
         hs_q    <= hs;
         vs_q    <= vs;
         first_q <= first;
      end
   end

   // Bar index = number of bar boundaries passed; saturates at 7 so the last bar takes the remainder.
   always_comb begin
      bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (32'(pix_x) >= 32'(i) * BAR_W) bar = bar + 3'd1;
      end
      on_grid = (pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0) ||
                (32'(pix_x) == X_MAX) || (32'(pix_y) == Y_MAX);
      case (mode_q)
         MODE_EXT:  colour = pix_data;
         MODE_BARS: colour = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
         MODE_GRID: colour = on_grid ? 24'hFFFFFF : 24'h000000;
         default:   colour = SOLID;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_de      <= 1'b0;
         lcd_hsync   <= ~HS_POL;
         lcd_vsync   <= ~VS_POL;
         lcd_r       <= 8'd0;
         lcd_g       <= 8'd0;
         lcd_b       <= 8'd0;
         frame_start <= 1'b0;
      end else begin
         lcd_de                <= pix_req;
         lcd_hsync             <= hs_q ? HS_POL : ~HS_POL;
         lcd_vsync             <= vs_q ? VS_POL : ~VS_POL;
         {lcd_r, lcd_g, lcd_b} <= pix_req ? colour : 24'd0;
         frame_start           <= first_q;
      end
   end

endmodule
